apb_bus_arbiter: RTL and testbench

Two-master to N-slave APB interconnect controller for the peripheral subsystem. It shares the APB peripheral bus (UART, GPIO, SPI master, timer) between two APB masters, for example the AXI2APB bridge and a debug/boot path. It provides round-robin arbitration, slave decode from the upper address bits, a registered SETUP/ACCESS sequencer, and decode-error responses. An optional access timeout can be compiled in.

---
 rtl/apb_bus_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: shares one APB peripheral bus between two APB masters.
// Round-robin arbitration, slave decode from the address bits above
// APB_ADDR_WIDTH, a registered SETUP/ACCESS sequencer, and decode-error responses.
// Optional build macro APB_ARB_TIMEOUT_EN aborts an ACCESS phase that runs
// TIMEOUT_CYCLES cycles without PREADY. The response is PSLVERR with read data 32'hDEAD_BEEF.
module apb_bus_arbiter #(
  parameter int NUM_SLAVES     = 4,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int SEL_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [1:0]                                   m_psel,
  input  logic [1:0]                                   m_penable,
  input  logic [1:0]                                   m_pwrite,
  input  logic [1:0][APB_ADDR_WIDTH+SEL_WIDTH-1:0]     m_paddr,
  input  logic [1:0][31:0]                             m_pwdata,
  output logic [1:0][31:0]                             m_prdata,
  output logic [1:0]                                   m_pready,
  output logic [1:0]                                   m_pslverr,
  output logic [NUM_SLAVES-1:0]                        s_psel,
  output logic                                         s_penable,
  output logic                                         s_pwrite,
  output logic [APB_ADDR_WIDTH-1:0]                    s_paddr,
  output logic [31:0]                                  s_pwdata,
  input  logic [NUM_SLAVES-1:0][31:0]                  s_prdata,
  input  logic [NUM_SLAVES-1:0]                        s_pready,
  input  logic [NUM_SLAVES-1:0]                        s_pslverr
);

  localparam int MAW = APB_ADDR_WIDTH + SEL_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  // last_q: master granted most recently. owner_q: master owning the current transfer.
  logic last_q, last_d;
  logic owner_q, owner_d;

  // Next values of the registered outputs.
  logic [NUM_SLAVES-1:0] s_psel_d;
  logic                  s_penable_d;
  logic                  s_pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] s_paddr_d;
  logic [31:0]           s_pwdata_d;
  logic [1:0]            m_pready_d;
  logic [1:0]            m_pslverr_d;
  logic [1:0][31:0]      m_prdata_d;

  // Arbitration and decode of the request being considered in IDLE.
  logic                  gnt;
  logic [SEL_WIDTH-1:0]  gnt_idx;
  logic                  gnt_hit;
  logic [NUM_SLAVES-1:0] gnt_onehot;

  // Response of the currently selected slave.
  logic                  sel_ready;
  logic                  sel_err;
  logic [31:0]           sel_rdata;

  // The arbiter runs its own SETUP/ACCESS phases, so master PENABLE carries no
  // information it needs. The signal is kept only for interface completeness.
  logic unused_penable;
  assign unused_penable = ^m_penable;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_q, tmo_d, tmo_next;
  logic          tmo_expired;

  // Count of ACCESS cycles spent without PREADY. The abort fires when the count reaches the limit.
  always_comb begin
    tmo_next    = tmo_q + 1'b1;
    tmo_expired = (tmo_next == TW'(TIMEOUT_CYCLES));
  end
`endif

  // Round-robin pick: a lone requester wins; on a tie the master not granted last wins.
  always_comb begin
    gnt     = (m_psel == 2'b11) ? ~last_q : m_psel[1];
    gnt_idx = m_paddr[gnt][MAW-1:APB_ADDR_WIDTH];
    gnt_hit = (int'(gnt_idx) < NUM_SLAVES);
    for (int j = 0; j < NUM_SLAVES; j++) begin
      gnt_onehot[j] = (int'(gnt_idx) == j);
    end
  end

  // AND-OR mux of the selected slave's response. s_psel is one-hot or all zero.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (s_psel[j]) begin
        sel_ready = sel_ready | s_pready[j];
        sel_err   = sel_err   | s_pslverr[j];
        sel_rdata = sel_rdata | s_prdata[j];
      end
    end
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    // NOTE: every signal gets a default before the case; a path that skipped an
    // assignment would otherwise infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    s_psel_d    = s_psel;
    s_penable_d = s_penable;
    s_pwrite_d  = s_pwrite;
    s_paddr_d   = s_paddr;
    s_pwdata_d  = s_pwdata;
    m_pready_d  = '0;
    m_pslverr_d = '0;
    m_prdata_d  = '0;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (m_psel != 2'b00) begin
          last_d     = gnt;
          owner_d    = gnt;
          s_pwrite_d = m_pwrite[gnt];
          s_paddr_d  = m_paddr[gnt][APB_ADDR_WIDTH-1:0];
          s_pwdata_d = m_pwdata[gnt];
          if (gnt_hit) begin
            state_d     = ST_SETUP;
            s_psel_d    = gnt_onehot;
            s_penable_d = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_d       = '0;
`endif
          end else begin
            // An unmapped slave index never reaches the bus. Answer with an error right away.
            state_d             = ST_RESP;
            m_pready_d[gnt]     = 1'b1;
            m_pslverr_d[gnt]    = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        state_d     = ST_ACCESS;
        s_penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (sel_ready) begin
          state_d                 = ST_RESP;
          s_psel_d                = '0;
          s_penable_d             = 1'b0;
          m_pready_d[owner_q]     = 1'b1;
          m_pslverr_d[owner_q]    = sel_err;
          m_prdata_d[owner_q]     = sel_rdata;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else begin
          tmo_d = tmo_next;
          if (tmo_expired) begin
            state_d               = ST_RESP;
            s_psel_d              = '0;
            s_penable_d           = 1'b0;
            m_pready_d[owner_q]   = 1'b1;
            m_pslverr_d[owner_q]  = 1'b1;
            m_prdata_d[owner_q]   = 32'hDEAD_BEEF;
          end
        end
`endif
      end

      ST_RESP: begin
        // The PREADY pulse clears through the defaults. Return to IDLE to arbitrate again.
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, arbitration pointer and registered outputs. Reset clears everything
  // asynchronously and points the arbiter so that master 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      s_psel    <= '0;
      s_penable <= 1'b0;
      s_pwrite  <= 1'b0;
      s_paddr   <= '0;
      s_pwdata  <= '0;
      m_pready  <= '0;
      m_pslverr <= '0;
      m_prdata  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments give every register its value from
      // before this edge, whatever order the statements appear in.
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      s_psel    <= s_psel_d;
      s_penable <= s_penable_d;
      s_pwrite  <= s_pwrite_d;
      s_paddr   <= s_paddr_d;
      s_pwdata  <= s_pwdata_d;
      m_pready  <= m_pready_d;
      m_pslverr <= m_pslverr_d;
      m_prdata  <= m_prdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Bench for apb_bus_arbiter. The main instance has four slaves, served by a
// behavioural wait-state slave model. A second instance has three slaves and is used for decode errors.
// Responses go through a scoreboard queue that a negedge monitor pops.
module tb_apb_bus_arbiter;
  localparam int NS  = 4;
  localparam int AW  = 12;
  localparam int SW  = 2;
  localparam int MAW = AW + SW;
  localparam int TMO = 16;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int HOLD = 5;
`else
  localparam int HOLD = 1000;
`endif
  localparam logic [31:0] SLV_DATA [NS] = '{32'h1111_0000, 32'h2222_0001,
                                             32'h3333_0002, 32'h4444_0003};

  typedef struct packed {
    logic           w;
    logic [MAW-1:0] a;
    logic [31:0]    d;
  } req_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        err;
    int          rel;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   cyc = 0;
  int   base_cyc = 0;
  int   total = 0;
  int   bad = 0;

  // Main instance
  logic [1:0]                m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [1:0][MAW-1:0]       m_paddr;
  logic [1:0][31:0]          m_pwdata, m_prdata;
  logic [NS-1:0]             s_psel, s_pready, s_pslverr;
  logic                      s_penable, s_pwrite;
  logic [AW-1:0]             s_paddr;
  logic [31:0]               s_pwdata;
  logic [NS-1:0][31:0]       s_prdata;

  // Three-slave instance
  logic [1:0]                u3_m_psel, u3_m_penable, u3_m_pwrite, u3_m_pready, u3_m_pslverr;
  logic [1:0][MAW-1:0]       u3_m_paddr;
  logic [1:0][31:0]          u3_m_pwdata, u3_m_prdata;
  logic [2:0]                u3_s_psel, u3_s_pready, u3_s_pslverr;
  logic                      u3_s_penable, u3_s_pwrite;
  logic [AW-1:0]             u3_s_paddr;
  logic [31:0]               u3_s_pwdata;
  logic [2:0][31:0]          u3_s_prdata;

  assign u3_s_prdata  = {3{32'hFFFF_FFFF}};
  assign u3_s_pready  = 3'b111;
  assign u3_s_pslverr = 3'b000;

  // Slave model configuration
  int   slv_wait [NS];
  logic slv_err  [NS];
  logic slv_hang [NS];
  int   slv_cnt  [NS];

  req_t pend0[$];
  req_t pend1[$];
  exp_t sb[$];

  apb_bus_arbiter #(
    .NUM_SLAVES(NS), .APB_ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
    .s_pready(s_pready), .s_pslverr(s_pslverr)
  );

  apb_bus_arbiter #(
    .NUM_SLAVES(3), .APB_ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut3 (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_psel(u3_m_psel), .m_penable(u3_m_penable), .m_pwrite(u3_m_pwrite),
    .m_paddr(u3_m_paddr), .m_pwdata(u3_m_pwdata), .m_prdata(u3_m_prdata),
    .m_pready(u3_m_pready), .m_pslverr(u3_m_pslverr),
    .s_psel(u3_s_psel), .s_penable(u3_s_penable), .s_pwrite(u3_s_pwrite),
    .s_paddr(u3_s_paddr), .s_pwdata(u3_s_pwdata), .s_prdata(u3_s_prdata),
    .s_pready(u3_s_pready), .s_pslverr(u3_s_pslverr)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Slave model: counts ACCESS cycles and raises PREADY after slv_wait wait states.
  always @(posedge clk_i) begin
    for (int j = 0; j < NS; j++) begin
      slv_cnt[j] <= (s_psel[j] && s_penable) ? slv_cnt[j] + 1 : 0;
    end
  end

  always_comb begin
    s_prdata  = '0;
    s_pready  = '0;
    s_pslverr = '0;
    for (int j = 0; j < NS; j++) begin
      s_prdata[j]  = SLV_DATA[j];
      s_pready[j]  = s_psel[j] && s_penable && !slv_hang[j] && (slv_cnt[j] >= slv_wait[j]);
      s_pslverr[j] = slv_err[j] && s_pready[j];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: quiet outputs while PREADY is low, and a scoreboard pop on every PREADY.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      check("single_pready", 32'(m_pready == 2'b11), 32'd0);
      for (int i = 0; i < 2; i++) begin
        if (!m_pready[i]) begin
          check("quiet_when_not_ready", m_prdata[i] | 32'(m_pslverr[i]), 32'd0);
        end else if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pready: master %0d at rel cycle %0d, none expected", i, cyc - base_cyc);
        end else begin
          e = sb.pop_front();
          check("resp_master", 32'(i), 32'(e.m));
          check("resp_prdata", m_prdata[i], e.data);
          check("resp_pslverr", 32'(m_pslverr[i]), 32'(e.err));
          if (e.rel >= 0) check("resp_cycle", 32'(cyc - base_cyc), 32'(e.rel));
        end
      end
    end
  end

  task automatic expect_resp(input int m, input logic [31:0] data, input logic err, input int rel);
    exp_t e;
    e.m = m; e.data = data; e.err = err; e.rel = rel;
    sb.push_back(e);
  endtask

  task automatic load(input int i);
    req_t r;
    if (i == 0 && pend0.size() > 0) begin
      r = pend0.pop_front();
    end else if (i == 1 && pend1.size() > 0) begin
      r = pend1.pop_front();
    end else begin
      m_psel[i]    = 1'b0;
      m_penable[i] = 1'b0;
      return;
    end
    m_psel[i]    = 1'b1;
    m_penable[i] = 1'b0;
    m_pwrite[i]  = r.w;
    m_paddr[i]   = r.a;
    m_pwdata[i]  = r.d;
  endtask

  // Drive both masters from their pending queues until both are drained.
  task automatic run(input int budget);
    int n;
    logic [1:0] seen;
    @(posedge clk_i); #1;
    base_cyc = cyc;
    load(0);
    load(1);
    n = 0;
    while (m_psel != 2'b00 && n < budget) begin
      @(negedge clk_i);
      seen = m_pready;
      @(posedge clk_i); #1;
      for (int i = 0; i < 2; i++) begin
        if (seen[i]) load(i);
        else if (m_psel[i]) m_penable[i] = 1'b1;
      end
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL run_budget: masters still busy after %0d cycles", budget);
      m_psel = '0;
    end
  endtask

  task automatic at_cyc(input int n);
    do @(negedge clk_i); while (cyc < n);
  endtask

  initial begin
    int c;
    for (int j = 0; j < NS; j++) begin
      slv_wait[j] = 0; slv_err[j] = 1'b0; slv_hang[j] = 1'b0;
    end
    m_psel = '0; m_penable = '0; m_pwrite = '0; m_paddr = '0; m_pwdata = '0;
    u3_m_psel = '0; u3_m_penable = '0; u3_m_pwrite = '0; u3_m_paddr = '0; u3_m_pwdata = '0;
    rst_i = 1'b1;

    // Reset values
    repeat (2) @(negedge clk_i);
    check("rst_s_psel", 32'(s_psel), 32'd0);
    check("rst_s_penable", 32'(s_penable), 32'd0);
    check("rst_s_paddr", 32'(s_paddr), 32'd0);
    check("rst_s_pwdata", s_pwdata, 32'd0);
    check("rst_m_pready", 32'(m_pready), 32'd0);
    check("rst_m_prdata", m_prdata[0] | m_prdata[1], 32'd0);
    check("rst_u3_s_psel", 32'(u3_s_psel), 32'd0);
    rst_i = 1'b0;

    // Simultaneous reads, four each: grants alternate starting with m0
    for (int k = 0; k < 4; k++) begin
      pend0.push_back('{1'b0, 14'h0000, 32'h0});
      pend1.push_back('{1'b0, 14'h3004, 32'h0});
      expect_resp(0, SLV_DATA[0], 1'b0, 3 + 8 * k);
      expect_resp(1, SLV_DATA[3], 1'b0, 7 + 8 * k);
    end
    run(200);

    // m0 write to slave 1, zero wait states
    @(posedge clk_i); #1;
    base_cyc = cyc;
    pend0.push_back('{1'b1, 14'h1008, 32'hA5A5_0001});
    expect_resp(0, SLV_DATA[1], 1'b0, 3);
    load(0);
    at_cyc(base_cyc + 1);
    check("wr_setup_psel", 32'(s_psel), 32'h2);
    check("wr_setup_penable", 32'(s_penable), 32'd0);
    check("wr_setup_paddr", 32'(s_paddr), 32'h008);
    check("wr_setup_pwrite", 32'(s_pwrite), 32'd1);
    check("wr_setup_pwdata", s_pwdata, 32'hA5A5_0001);
    at_cyc(base_cyc + 2);
    check("wr_access_psel", 32'(s_psel), 32'h2);
    check("wr_access_penable", 32'(s_penable), 32'd1);
    at_cyc(base_cyc + 3);
    @(posedge clk_i); #1;
    load(0);
    at_cyc(base_cyc + 4);
    check("wr_after_psel", 32'(s_psel), 32'd0);
    check("wr_after_penable", 32'(s_penable), 32'd0);
    check("wr_hold_pwdata", s_pwdata, 32'hA5A5_0001);
    check("wr_hold_pwrite", 32'(s_pwrite), 32'd1);

    // Slave 2 with 5 wait states then PSLVERR (m1 wins the tie), m0 waits its turn
    slv_wait[2] = 5;
    slv_err[2]  = 1'b1;
    pend1.push_back('{1'b0, 14'h2010, 32'h0});
    pend0.push_back('{1'b0, 14'h0000, 32'h0});
    expect_resp(1, SLV_DATA[2], 1'b1, 8);
    expect_resp(0, SLV_DATA[0], 1'b0, 12);
    run(100);
    slv_wait[2] = 0;
    slv_err[2]  = 1'b0;

    // Three-slave instance: index 3 is unmapped, so a decode error is returned
    @(posedge clk_i); #1;
    c = cyc;
    u3_m_psel[1]  = 1'b1;
    u3_m_paddr[1] = 14'h3000;
    at_cyc(c + 1);
    check("dec_pready", 32'(u3_m_pready), 32'h2);
    check("dec_pslverr", 32'(u3_m_pslverr), 32'h2);
    check("dec_prdata", u3_m_prdata[1], 32'd0);
    check("dec_no_psel", 32'(u3_s_psel), 32'd0);
    @(posedge clk_i); #1;
    u3_m_psel[1]  = 1'b0;
    c = cyc + 1;
    @(posedge clk_i); #1;
    u3_m_psel[0]  = 1'b1;
    u3_m_paddr[0] = 14'h2000;
    at_cyc(c + 1);
    check("dec_ok_psel", 32'(u3_s_psel), 32'h4);
    at_cyc(c + 3);
    check("dec_ok_pready", 32'(u3_m_pready), 32'h1);
    check("dec_ok_prdata", u3_m_prdata[0], 32'hFFFF_FFFF);
    check("dec_ok_pslverr", 32'(u3_m_pslverr), 32'd0);
    @(posedge clk_i); #1;
    u3_m_psel[0] = 1'b0;

    slv_hang[1] = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
    // Slave never ready: the arbiter aborts after TMO ACCESS cycles
    pend1.push_back('{1'b0, 14'h1000, 32'h0});
    expect_resp(1, 32'hDEAD_BEEF, 1'b1, 2 + TMO);
    run(100);
`endif

    // Hung ACCESS, then an asynchronous reset in the middle of it
    @(posedge clk_i); #1;
    base_cyc = cyc;
    pend1.push_back('{1'b0, 14'h1004, 32'h0});
    load(1);
    at_cyc(base_cyc + HOLD);
    check("hang_penable", 32'(s_penable), 32'd1);
    check("hang_psel", 32'(s_psel), 32'h2);
    check("hang_pready", 32'(m_pready), 32'd0);
    #1;
    rst_i  = 1'b1;
    m_psel = '0;
    m_penable = '0;
    #1;
    check("async_rst_psel", 32'(s_psel), 32'd0);
    check("async_rst_penable", 32'(s_penable), 32'd0);
    check("async_rst_pready", 32'(m_pready), 32'd0);
    slv_hang[1] = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // After reset, m0 wins a tie
    pend0.push_back('{1'b0, 14'h0000, 32'h0});
    pend1.push_back('{1'b0, 14'h3004, 32'h0});
    expect_resp(0, SLV_DATA[0], 1'b0, 3);
    expect_resp(1, SLV_DATA[3], 1'b0, 7);
    run(50);

    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
